// File: rtl/init_values_loader.sv
// init_values_loader
// Collects a stream of narrow words on a valid/ready interface, packs every
// BEATS words MSB-first into one table entry and writes the DEPTH entries in
// order through a single write port of the init-value RAM.  Loading is started
// by a start pulse, can be cancelled with abort and ends in DONE once the last
// entry has been written.
module init_values_loader #(
   parameter int DATA_W = 64,
   parameter int IN_W   = 16,
   parameter int DEPTH  = 8,
   localparam int ADDR_W = $clog2(DEPTH),
   localparam int BEATS  = DATA_W / IN_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic              in_valid,
   input  logic [IN_W-1:0]   in_data,
   output logic              in_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic [ADDR_W:0]   entries_loaded,
   output logic              busy,
   output logic              done
);

   // Beat counter width; a single-beat configuration still gets one bit.
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   // Only the words that precede the current one have to be stored.
   localparam int SHIFT_W = DATA_W - IN_W;

   localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BEATS - 1);
   localparam logic [ADDR_W-1:0] LAST_ENTRY = ADDR_W'(DEPTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
   logic [ADDR_W-1:0]   entry_cnt_q, entry_cnt_d;
   logic [SHIFT_W-1:0]  shift_q, shift_d;
   logic                wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0]   wr_data_q, wr_data_d;
   logic [ADDR_W:0]     loaded_q, loaded_d;

   logic                accept_s;
   logic                last_beat_s;
   logic                last_entry_s;
   logic [DATA_W-1:0]   assembled_s;

   // Appends the newest word below the already collected ones, so the first
   // word of an entry lands in the most significant slice.
   function automatic logic [DATA_W-1:0] assemble(
      input logic [SHIFT_W-1:0] partial,
      input logic [IN_W-1:0]    word
   );
      return {partial, word};
   endfunction

   // A word is taken only while loading; in_ready comes from the state
   // register alone, so there is no path from in_valid back to in_ready.
   assign accept_s     = in_valid && (state_q == ST_LOAD);
   assign last_beat_s  = (beat_cnt_q == LAST_BEAT);
   assign last_entry_s = (entry_cnt_q == LAST_ENTRY);
   assign assembled_s  = assemble(shift_q, in_data);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: start wins outside LOAD, abort wins inside LOAD.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_LOAD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOAD: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (accept_s && last_beat_s && last_entry_s) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_LOAD;
            end
         end
         ST_DONE: begin
            if (start) begin
               state_d = ST_LOAD;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Datapath and write-port next values; every counter holds unless changed.
   always_comb begin
      beat_cnt_d  = beat_cnt_q;
      entry_cnt_d = entry_cnt_q;
      shift_d     = shift_q;
      wr_en_d     = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      loaded_d    = loaded_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               beat_cnt_d  = '0;
               entry_cnt_d = '0;
               shift_d     = '0;
               loaded_d    = '0;
            end else begin
               beat_cnt_d  = beat_cnt_q;
               entry_cnt_d = entry_cnt_q;
            end
         end
         ST_LOAD: begin
            if (abort) begin
               // The partial entry and any word arriving with abort are
               // dropped; entries already written are left alone.
               beat_cnt_d = '0;
               shift_d    = '0;
            end else if (accept_s) begin
               shift_d = assembled_s[SHIFT_W-1:0];
               if (last_beat_s) begin
                  beat_cnt_d  = '0;
                  wr_en_d     = 1'b1;
                  wr_addr_d   = entry_cnt_q;
                  wr_data_d   = assembled_s;
                  entry_cnt_d = entry_cnt_q + ADDR_W'(1);
                  loaded_d    = loaded_q + (ADDR_W + 1)'(1);
               end else begin
                  beat_cnt_d = beat_cnt_q + BEAT_W'(1);
               end
            end else begin
               beat_cnt_d = beat_cnt_q;
            end
         end
         default: begin
            beat_cnt_d  = '0;
            entry_cnt_d = '0;
            shift_d     = '0;
         end
      endcase
   end

   // Datapath registers; reset clears everything immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat_cnt_q  <= '0;
         entry_cnt_q <= '0;
         shift_q     <= '0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         loaded_q    <= '0;
      end else begin
         beat_cnt_q  <= beat_cnt_d;
         entry_cnt_q <= entry_cnt_d;
         shift_q     <= shift_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         loaded_q    <= loaded_d;
      end
   end

   // Status flags decode straight from the state register.
   assign in_ready       = (state_q == ST_LOAD);
   assign busy           = (state_q == ST_LOAD);
   assign done           = (state_q == ST_DONE);
   assign wr_en          = wr_en_q;
   assign wr_addr        = wr_addr_q;
   assign wr_data        = wr_data_q;
   assign entries_loaded = loaded_q;

endmodule

// File: tb/tb_init_values_loader.sv
// Directed bench for init_values_loader: full loads, gapped input, reload,
// abort, protocol corner cases and asynchronous reset.
module tb_init_values_loader;

   localparam int DATA_W = 64;
   localparam int IN_W   = 16;
   localparam int DEPTH  = 8;
   localparam int ADDR_W = 3;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic              in_valid = 1'b0;
   logic [IN_W-1:0]   in_data = 16'h0000;
   logic              in_ready;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [ADDR_W:0]   entries_loaded;
   logic              busy;
   logic              done;

   int n_total = 0;
   int n_pass  = 0;
   int cyc     = 0;

   logic [ADDR_W-1:0] log_addr[$];
   logic [DATA_W-1:0] log_data[$];
   int                log_cyc[$];

   init_values_loader #(.DATA_W(DATA_W), .IN_W(IN_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .entries_loaded(entries_loaded), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Cycle counter for write spacing.
   always @(posedge clk) cyc <= cyc + 1;

   // Write monitor, sampled just after each rising edge.
   always @(posedge clk) begin
      #1;
      if (wr_en === 1'b1) begin
         log_addr.push_back(wr_addr);
         log_data.push_back(wr_data);
         log_cyc.push_back(cyc);
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   function automatic logic [63:0] exp_entry(input logic [15:0] first, input bit down);
      logic [63:0] e;
      logic [15:0] w;
      e = 64'h0;
      w = first;
      for (int b = 0; b < 4; b++) begin
         e = {e[47:0], w};
         w = down ? (w - 16'd1) : (w + 16'd1);
      end
      return e;
   endfunction

   task automatic clear_log();
      log_addr.delete();
      log_data.delete();
      log_cyc.delete();
   endtask

   task automatic check_log(input string p, input int n, input bit down, input bit spacing);
      logic [15:0] first;
      chk({p, "_nwrites"}, 64'(log_addr.size()), 64'(n));
      for (int k = 0; k < n && k < log_addr.size(); k++) begin
         first = down ? (16'hFFFF - 16'(4 * k)) : (16'(4 * k) + 16'd1);
         chk($sformatf("%s_addr%0d", p, k), 64'(log_addr[k]), 64'(k));
         chk($sformatf("%s_data%0d", p, k), log_data[k], exp_entry(first, down));
         if (spacing && k > 0)
            chk($sformatf("%s_gap%0d", p, k), 64'(log_cyc[k] - log_cyc[k-1]), 64'd4);
      end
   endtask

   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic beat(input logic [15:0] d);
      in_valid = 1'b1;
      in_data  = d;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   initial begin
      // Reset state, before any clock activity matters
      #2;
      chk("rst_wr_en", 64'(wr_en), 64'd0);
      chk("rst_wr_addr", 64'(wr_addr), 64'd0);
      chk("rst_wr_data", wr_data, 64'd0);
      chk("rst_loaded", 64'(entries_loaded), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_in_ready", 64'(in_ready), 64'd0);

      // Full load, valid held high
      clear_log();
      do_start();
      chk("full_busy", 64'(busy), 64'd1);
      chk("full_in_ready", 64'(in_ready), 64'd1);
      for (int i = 1; i <= 32; i++) beat(16'(i));
      chk("full_last_wr_en", 64'(wr_en), 64'd1);
      chk("full_last_addr", 64'(wr_addr), 64'd7);
      chk("full_done", 64'(done), 64'd1);
      chk("full_loaded", 64'(entries_loaded), 64'd8);
      chk("full_in_ready_low", 64'(in_ready), 64'd0);
      @(negedge clk);
      chk("full_wr_en_drop", 64'(wr_en), 64'd0);
      chk("full_addr_hold", 64'(wr_addr), 64'd7);
      chk("full_data_hold", wr_data, exp_entry(16'd29, 1'b0));
      check_log("full", 8, 1'b0, 1'b1);

      // Reload with gaps, plus a start pulse in the middle of LOAD
      clear_log();
      do_start();
      chk("gap_done_fall", 64'(done), 64'd0);
      chk("gap_loaded_clr", 64'(entries_loaded), 64'd0);
      for (int i = 1; i <= 32; i++) begin
         for (int g = 0; g < (i % 3); g++) begin
            in_valid = 1'b0;
            in_data  = 16'hDEAD;
            @(negedge clk);
         end
         if (i == 6) start = 1'b1;
         beat(16'(i));
         start = 1'b0;
         if (i == 6) begin
            chk("ld_start_busy", 64'(busy), 64'd1);
            chk("ld_start_loaded", 64'(entries_loaded), 64'd1);
         end
      end
      chk("gap_done", 64'(done), 64'd1);
      @(negedge clk);
      check_log("gap", 8, 1'b0, 1'b0);

      // Abort in DONE is ignored; no beat accepted after DONE
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_done_done", 64'(done), 64'd1);
      chk("abort_done_loaded", 64'(entries_loaded), 64'd8);
      in_valid = 1'b1;
      in_data  = 16'h0021;
      repeat (3) @(negedge clk);
      chk("extra_in_ready", 64'(in_ready), 64'd0);
      chk("extra_nwrites", 64'(log_addr.size()), 64'd8);
      in_valid = 1'b0;

      // Reload from DONE with descending words
      clear_log();
      do_start();
      chk("rel_done_fall", 64'(done), 64'd0);
      for (int i = 0; i < 32; i++) beat(16'hFFFF - 16'(i));
      chk("rel_done", 64'(done), 64'd1);
      chk("rel_loaded", 64'(entries_loaded), 64'd8);
      @(negedge clk);
      check_log("rel", 8, 1'b1, 1'b1);

      // Abort together with the 10th beat
      clear_log();
      do_start();
      for (int i = 1; i <= 9; i++) beat(16'(i));
      abort = 1'b1;
      beat(16'd10);
      abort = 1'b0;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_in_ready", 64'(in_ready), 64'd0);
      chk("abort_loaded", 64'(entries_loaded), 64'd2);
      in_valid = 1'b1;
      repeat (4) @(negedge clk);
      in_valid = 1'b0;
      check_log("abort", 2, 1'b0, 1'b1);

      // Abort on the final beat of an entry: no write
      clear_log();
      do_start();
      chk("abl_loaded_clr", 64'(entries_loaded), 64'd0);
      for (int i = 1; i <= 3; i++) beat(16'(i));
      abort = 1'b1;
      beat(16'd4);
      abort = 1'b0;
      chk("abl_wr_en", 64'(wr_en), 64'd0);
      @(negedge clk);
      chk("abl_nwrites", 64'(log_addr.size()), 64'd0);
      chk("abl_loaded", 64'(entries_loaded), 64'd0);
      chk("abl_busy", 64'(busy), 64'd0);

      // Restart from addr0, then reset asynchronously mid-entry 5 (beat 2)
      clear_log();
      do_start();
      for (int i = 1; i <= 4; i++) beat(16'(i));
      chk("re_wr_en", 64'(wr_en), 64'd1);
      chk("re_addr", 64'(wr_addr), 64'd0);
      chk("re_data", wr_data, exp_entry(16'd1, 1'b0));
      for (int i = 5; i <= 18; i++) beat(16'(i));
      in_valid = 1'b1;
      in_data  = 16'd19;
      #2;
      rst = 1'b1;
      #1;
      chk("arst_wr_en", 64'(wr_en), 64'd0);
      chk("arst_wr_addr", 64'(wr_addr), 64'd0);
      chk("arst_wr_data", wr_data, 64'd0);
      chk("arst_loaded", 64'(entries_loaded), 64'd0);
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_in_ready", 64'(in_ready), 64'd0);
      chk("arst_done", 64'(done), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      in_valid = 1'b0;
      chk("post_rst_busy", 64'(busy), 64'd0);
      check_log("prerst", 4, 1'b0, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
